// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader for per-node instruction memories
//
// Purpose: decodes [node_id][cnt_lo][cnt_hi][4*cnt data bytes, LSB first]
//   (plus a trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined),
//   assembles little-endian 32-bit words and issues one-cycle writes into the
//   selected node's instruction memory while holding that node's core in reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_data/s_valid      input byte stream
//   s_ready             byte accepted when s_valid && s_ready at a rising edge
//   wr_en/wr_node/      instruction-memory write strobe, node id,
//   wr_addr/wr_data     word index and assembled word
//   core_hold           per-node core reset request (active-high)
//   busy                frame in progress
//   done                one-cycle pulse on successful frame completion
//   err                 sticky frame error, cleared by reset or next node-id byte
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN

module imem_loader #(
  parameter int SIZE     = 128,
  parameter int NODE_CNT = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                wr_en,
  output logic [3:0]          wr_node,
  output logic [31:0]         wr_addr,
  output logic [31:0]         wr_data,
  output logic [NODE_CNT-1:0] core_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHK, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, FIN} state_t;
`endif

  localparam logic [7:0]  NODE_LIM = 8'(NODE_CNT);
  localparam logic [15:0] SIZE_LIM = 16'(SIZE);

  state_t               state, state_n;
  logic [7:0]           node_id;
  logic [15:0]          cnt;
  logic [15:0]          idx;
  logic [1:0]           bcnt;
  logic [23:0]          word_buf;   // bytes 0..2 of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           chk;
`endif

  logic                 acc;
  logic [15:0]          cnt_full;
  logic                 hdr_bad;
  logic                 last_word;
  logic [NODE_CNT-1:0]  node_mask;

  assign acc       = s_valid && s_ready;
  assign cnt_full  = {s_data, cnt[7:0]};
  assign hdr_bad   = (node_id >= NODE_LIM) || (cnt_full == 16'd0) || (cnt_full > SIZE_LIM);
  assign last_word = (bcnt == 2'd3) && (idx == cnt - 16'd1);
  // Only dereferenced after a good header, so node_id is in range whenever it matters.
  assign node_mask = NODE_CNT'(1) << node_id;

  // s_ready is gated by rst_n so it reads 0 throughout reset, not just after it.
  assign s_ready = rst_n && (state != FIN);
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (acc) state_n = CNT_LO;
      CNT_LO: if (acc) state_n = CNT_HI;
      CNT_HI: if (acc) state_n = hdr_bad ? IDLE : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      DATA:   if (acc && last_word) state_n = CHK;
      CHK:    if (acc) state_n = (s_data == chk) ? FIN : IDLE;
`else
      DATA:   if (acc && last_word) state_n = FIN;
`endif
      FIN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_id   <= '0;
      cnt       <= '0;
      idx       <= '0;
      bcnt      <= '0;
      word_buf  <= '0;
      wr_en     <= 1'b0;
      wr_node   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      core_hold <= '0;
      err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          node_id <= s_data;
          err     <= 1'b0;
        end
        CNT_LO: if (acc) cnt[7:0] <= s_data;
        CNT_HI: if (acc) begin
          cnt[15:8] <= s_data;
          if (hdr_bad) begin
            err <= 1'b1;
          end else begin
            core_hold <= core_hold | node_mask;
            idx       <= '0;
            bcnt      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk       <= '0;
`endif
          end
        end
        DATA: if (acc) begin
          bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk  <= chk ^ s_data;
`endif
          case (bcnt)
            2'd0: word_buf[7:0]   <= s_data;
            2'd1: word_buf[15:8]  <= s_data;
            2'd2: word_buf[23:16] <= s_data;
            default: begin
              wr_en   <= 1'b1;
              wr_node <= node_id[3:0];
              wr_addr <= {16'd0, idx};
              wr_data <= {s_data, word_buf};
              idx     <= idx + 16'd1;
            end
          endcase
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // On mismatch the node stays held; only a later good frame releases it.
        CHK: if (acc && (s_data != chk)) err <= 1'b1;
`endif
        FIN: core_hold <= core_hold & ~node_mask;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;
  localparam int SIZE = 128;
  localparam int NODE_CNT = 9;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0]          s_data;
  logic                s_valid;
  logic                s_ready;
  logic                wr_en;
  logic [3:0]          wr_node;
  logic [31:0]         wr_addr;
  logic [31:0]         wr_data;
  logic [NODE_CNT-1:0] core_hold;
  logic                busy;
  logic                done;
  logic                err;

  imem_loader #(.SIZE(SIZE), .NODE_CNT(NODE_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en(wr_en), .wr_node(wr_node), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  node;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t                 exp_q[$];
  int                  done_cnt = 0;
  logic [NODE_CNT-1:0] exp_hold = '0;
  logic [31:0]         wbuf[0:SIZE-1];

  // Write/done monitor: every wr_en cycle must match the next expected write.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      if (done) done_cnt++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'd1, 64'd0);
        end else begin
          w = exp_q.pop_front();
          check("wr_node", 64'(wr_node), 64'(w.node));
          check("wr_addr", 64'(wr_addr), 64'(w.addr));
          check("wr_data", 64'(wr_data), 64'(w.data));
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_wr"}, {wr_en, wr_node, wr_addr[26:0]}, 64'd0);
    check({tag, "_wdata"}, 64'(wr_data), 64'd0);
    check({tag, "_stat"}, {core_hold, busy, done, err}, 64'd0);
  endtask

  // Drive one byte after 'gap' idle cycles; returns at posedge+1 after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    rdy = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    if (!rdy) check("s_ready_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
  endtask

  // Reference model: a frame either loads cnt words at addr 0..cnt-1 or, with a
  // bad header, does nothing but raise err.
  task automatic send_frame(input int node, input int cnt, input int gap, input bit bad_chk);
    bit         good;
    int         d0;
    logic [7:0] x;
    logic [NODE_CNT-1:0] bit_n;
    wr_t        w;
    good  = (node < NODE_CNT) && (cnt >= 1) && (cnt <= SIZE);
    bit_n = good ? NODE_CNT'(1) << node : '0;
    d0    = done_cnt;
    x     = 8'h00;
    send_byte(8'(node), gap);
    send_byte(8'(cnt), gap);
    send_byte(8'(cnt >> 8), gap);
    @(negedge clk);
    check("hold_after_hdr", 64'(core_hold), 64'(exp_hold | bit_n));
    if (!good) begin
      check("bad_err", 64'(err), 64'd1);
      check("bad_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    for (int i = 0; i < cnt; i++) begin
      w.node = 4'(node);
      w.addr = 32'(i);
      w.data = wbuf[i];
      exp_q.push_back(w);
      for (int k = 0; k < 4; k++) begin
        send_byte(8'(wbuf[i] >> (8 * k)), gap);
        x = x ^ 8'(wbuf[i] >> (8 * k));
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? ~x : x, gap);
`else
    bad_chk = 1'b0;
`endif
    repeat (3) begin @(posedge clk); #1; end
    check("end_busy", 64'(busy), 64'd0);
    check("end_err", 64'(err), 64'(bad_chk));
    check("end_done", 64'(done_cnt - d0), bad_chk ? 64'd0 : 64'd1);
    check("end_pending", 64'(exp_q.size()), 64'd0);
    if (bad_chk) exp_hold = exp_hold | bit_n;
    else         exp_hold = exp_hold & ~bit_n;
    check("end_hold", 64'(core_hold), 64'(exp_hold));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int node, cnt, gap;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // Reference program to node 2, back-to-back then with 3 idle cycles per byte.
    wbuf[0] = 32'h00500293;
    wbuf[1] = 32'h005282B3;
    send_frame(2, 2, 0, 1'b0);
    send_frame(2, 2, 3, 1'b0);

    // Bad headers: node out of range, cnt 0, cnt SIZE+1.
    send_frame(9, 1, 0, 1'b0);
    send_frame(0, 0, 0, 1'b0);
    send_frame(0, SIZE + 1, 1, 1'b0);

    // Full memory to node 0.
    for (int i = 0; i < SIZE; i++) wbuf[i] = 32'(i);
    send_frame(0, SIZE, 0, 1'b0);

    // Reset after 6 data bytes of a node-1 frame.
    wbuf[0] = 32'hCAFE0001;
    wbuf[1] = 32'hCAFE0002;
    w_push(1, 0, wbuf[0]);
    send_byte(8'd1, 0);
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    for (int b = 0; b < 6; b++) send_byte(8'(wbuf[b / 4] >> (8 * (b % 4))), 0);
    check("mid_hold", 64'(core_hold), 64'h2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    exp_hold = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(1, 2, 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wbuf[0] = 32'h12345678;
    send_frame(3, 1, 0, 1'b0);
    send_frame(3, 1, 0, 1'b1);
    check("chk_hold3", 64'(core_hold[3]), 64'd1);
`endif

    // Randomized frames, including occasional bad headers.
    for (int f = 0; f < 10; f++) begin
      node = $urandom_range(0, 10);
      cnt  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      gap  = $urandom_range(0, 2);
      for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
      send_frame(node, cnt, gap, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic w_push(input int node, input int addr, input logic [31:0] data);
    wr_t w;
    w.node = 4'(node);
    w.addr = 32'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

endmodule
